// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return selection and a circular return-address stack.
// The new PC appears on PC_out one edge after its inputs are sampled; STALL freezes all state and has no handshake.
module pc_unit #(
  parameter int          WIDTH        = 32,
  parameter int          STEP         = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             BRANCH_EN,
  input  logic [15:0]      BRANCH_OFFSET,
  input  logic             JUMP_EN,
  input  logic [25:0]      JUMP_TARGET,
  input  logic             CALL,
  input  logic             RET,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] PC_PLUS,
  output logic             RAS_EMPTY,
  output logic             RAS_FULL,
  output logic [1:0]       RAS_ERR
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  // ptr is the next write slot; when the stack is full it also addresses the oldest entry
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       err;

  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;

  assign ptr_inc = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
  assign ptr_dec = (ptr == '0) ? PTR_MAX : ptr - 1'b1;

  assign PC_PLUS       = pc + WIDTH'(STEP);
  assign branch_target = PC_PLUS + {{(WIDTH-18){BRANCH_OFFSET[15]}}, BRANCH_OFFSET, 2'b00};
  assign jump_target   = {PC_PLUS[WIDTH-1:28], JUMP_TARGET, 2'b00};

  assign PC_out    = pc;
  assign RAS_EMPTY = (count == '0);
  assign RAS_FULL  = (count == CNT_MAX);
  assign RAS_ERR   = err;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pc    <= WIDTH'(RESET_VECTOR);
      ptr   <= '0;
      count <= '0;
      err   <= 2'b00;
    end else if (!STALL) begin
      if (RET) begin
        if (count != '0) begin
          pc    <= stack[ptr_dec];
          ptr   <= ptr_dec;
          count <= count - 1'b1;
        end else begin
          pc     <= PC_PLUS;
          err[1] <= 1'b1;
        end
      end else if (JUMP_EN) begin
        pc <= jump_target;
        if (CALL) begin
          stack[ptr] <= PC_PLUS;
          ptr        <= ptr_inc;
          if (count == CNT_MAX) begin
            err[0] <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
      end else if (BRANCH_EN) begin
        pc <= branch_target;
      end else begin
        pc <= PC_PLUS;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: two instances with different reset vectors share one stimulus stream.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic [1:0]  err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_EN;
  logic [15:0] BRANCH_OFFSET;
  logic        JUMP_EN;
  logic [25:0] JUMP_TARGET;
  logic        CALL;
  logic        RET;

  logic [31:0] pc_o   [2];
  logic [31:0] plus_o [2];
  logic        empty_o[2];
  logic        full_o [2];
  logic [1:0]  err_o  [2];

  logic [31:0] rv [2];
  logic [31:0] m_pc [2];
  logic [1:0]  m_err [2];
  logic [31:0] m_ras [2][$];
  exp_t        exp_q [2][$];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pc_unit u0 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_EN(BRANCH_EN),
    .BRANCH_OFFSET(BRANCH_OFFSET), .JUMP_EN(JUMP_EN), .JUMP_TARGET(JUMP_TARGET),
    .CALL(CALL), .RET(RET), .PC_out(pc_o[0]), .PC_PLUS(plus_o[0]),
    .RAS_EMPTY(empty_o[0]), .RAS_FULL(full_o[0]), .RAS_ERR(err_o[0])
  );

  pc_unit #(.RESET_VECTOR(32'h1000_0040)) u1 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_EN(BRANCH_EN),
    .BRANCH_OFFSET(BRANCH_OFFSET), .JUMP_EN(JUMP_EN), .JUMP_TARGET(JUMP_TARGET),
    .CALL(CALL), .RET(RET), .PC_out(pc_o[1]), .PC_PLUS(plus_o[1]),
    .RAS_EMPTY(empty_o[1]), .RAS_FULL(full_o[1]), .RAS_ERR(err_o[1])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got %h, expected %h", name, i, $time, act, want);
    end
  endtask

  // Reference: PC as an integer, stack as an unbounded LIFO trimmed from the bottom at RAS_DEPTH.
  task automatic model_step(input int i);
    logic [31:0] plus;
    exp_t e;
    plus = m_pc[i] + 32'd4;
    if (!RESET) begin
      m_pc[i]  = rv[i];
      m_err[i] = 2'b00;
      m_ras[i].delete();
    end else if (!STALL) begin
      if (RET) begin
        if (m_ras[i].size() > 0) begin
          m_pc[i] = m_ras[i].pop_back();
        end else begin
          m_pc[i]  = plus;
          m_err[i] = m_err[i] | 2'b10;
        end
      end else if (JUMP_EN) begin
        m_pc[i] = (plus & 32'hF000_0000) + 32'(JUMP_TARGET) * 32'd4;
        if (CALL) begin
          m_ras[i].push_back(plus);
          if (m_ras[i].size() > 4) begin
            void'(m_ras[i].pop_front());
            m_err[i] = m_err[i] | 2'b01;
          end
        end
      end else if (BRANCH_EN) begin
        m_pc[i] = plus + 32'(int'($signed(BRANCH_OFFSET)) * 4);
      end else begin
        m_pc[i] = plus;
      end
    end
    e.pc    = m_pc[i];
    e.empty = (m_ras[i].size() == 0);
    e.full  = (m_ras[i].size() == 4);
    e.err   = m_err[i];
    exp_q[i].push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic stall, input logic ret, input logic jmp,
                     input logic call, input logic br, input logic [15:0] off, input logic [25:0] tgt);
    RESET = rst; STALL = stall; RET = ret; JUMP_EN = jmp; CALL = call;
    BRANCH_EN = br; BRANCH_OFFSET = off; JUMP_TARGET = tgt;
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        chk("pc_out", i, pc_o[i], e.pc);
        chk("pc_plus", i, plus_o[i], e.pc + 32'd4);
        chk("ras_empty", i, 32'(empty_o[i]), 32'(e.empty));
        chk("ras_full", i, 32'(full_o[i]), 32'(e.full));
        chk("ras_err", i, 32'(err_o[i]), 32'(e.err));
      end
    end
  end

  initial begin
    rv[0] = 32'h0;
    rv[1] = 32'h1000_0040;
    m_pc[0] = '0; m_pc[1] = '0;
    m_err[0] = '0; m_err[1] = '0;

    cyc(0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc(0, 1, 1, 1, 1, 1, 16'h0, 26'h0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0);

    // Land on 0x100 then branch backward and forward
    cyc(1, 0, 0, 1, 0, 0, 16'h0, 26'h40);
    cyc(1, 0, 0, 0, 0, 1, 16'hFFFE, 26'h0);
    cyc(1, 0, 0, 1, 0, 0, 16'h0, 26'h40);
    cyc(1, 0, 0, 0, 0, 1, 16'h0003, 26'h0);

    // u1 restarts at 0x1000_0040 for the call/return pair
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc(1, 0, 0, 1, 1, 0, 16'h0, 26'h100);
    cyc(1, 0, 1, 0, 0, 0, 16'h0, 26'h0);

    // Overflow, LIFO drain, then underflow
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 1, 1, 0, 16'h0, 26'(32'h200 + k * 16));
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 0, 0, 16'h0, 26'h0);

    cyc(1, 0, 0, 1, 1, 0, 16'h0, 26'h300);
    cyc(1, 1, 1, 1, 1, 0, 16'h0, 26'h111);
    cyc(1, 1, 0, 1, 0, 1, 16'h8000, 26'h222);
    cyc(1, 1, 1, 0, 1, 0, 16'h7FFF, 26'h333);
    cyc(1, 0, 1, 1, 1, 0, 16'h0, 26'h0);
    cyc(1, 0, 0, 0, 1, 0, 16'h0, 26'h0);

    // Wrap past the top of the address space, then reset against STALL and RET
    cyc(0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc(1, 0, 0, 0, 0, 1, 16'hFFFE, 26'h0);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    cyc(1, 0, 0, 1, 1, 0, 16'h0, 26'h55);
    cyc(0, 1, 1, 1, 1, 1, 16'h0, 26'h0);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 26'h0);

    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0),
          16'($urandom), 26'($urandom));
    end

    @(posedge CLK);
    #2;
    for (int i = 0; i < 2; i++) chk("drain", i, 32'(exp_q[i].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
